// File: rtl/divsqrt_unpack.sv
// Operand unpack and special-case resolution for the div/sqrt unit,
// registered behind a two-entry in-order skid buffer.
module divsqrt_unpack #(
  parameter int BIAS = 1023
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] Float1,
  input  logic [63:0] Float2b,
  input  logic        op_type,
  input  logic        P,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sign,
  output logic [12:0] out_exp,
  output logic [53:0] out_mant1,
  output logic [53:0] out_mant2,
  output logic [1:0]  out_class,
  output logic [1:0]  out_flags,
  output logic        out_op_type,
  output logic        out_P
);

  localparam logic [1:0] C_NORM = 2'd0;
  localparam logic [1:0] C_ZERO = 2'd1;
  localparam logic [1:0] C_INF  = 2'd2;
  localparam logic [1:0] C_NAN  = 2'd3;

  typedef struct packed {
    logic        sign;
    logic [12:0] exp;
    logic [53:0] m1;
    logic [53:0] m2;
    logic [1:0]  cls;
    logic [1:0]  flg;
    logic        op;
    logic        p;
  } ent_t;

  logic        s1, s2;
  logic [10:0] e1, e2;
  logic [51:0] f1, f2;
  logic        zero1, inf1, nan1;
  logic        zero2, inf2, nan2;
  logic [12:0] u;
  ent_t        nxt;

  assign s1 = Float1[63];
  assign e1 = Float1[62:52];
  assign f1 = Float1[51:0];
  assign s2 = Float2b[63];
  assign e2 = Float2b[62:52];
  assign f2 = Float2b[51:0];

  // Denormals are treated as zero.
  assign zero1 = (e1 == 11'd0);
  assign inf1  = (e1 == 11'h7ff) && (f1 == 52'd0);
  assign nan1  = (e1 == 11'h7ff) && (f1 != 52'd0);
  assign zero2 = (e2 == 11'd0);
  assign inf2  = (e2 == 11'h7ff) && (f2 == 52'd0);
  assign nan2  = (e2 == 11'h7ff) && (f2 != 52'd0);

  assign u = {2'b00, e1} - 13'(BIAS);

  always_comb begin
    nxt    = '0;
    nxt.op = op_type;
    nxt.p  = P;
    if (!op_type) begin
      nxt.sign = s1 ^ s2;
      nxt.exp  = {2'b00, e1} - {2'b00, e2} + 13'(BIAS);
      nxt.m1   = {2'b01, f1};
      nxt.m2   = {2'b01, f2};
      if (nan1 || nan2) begin
        nxt.cls = C_NAN;
      end else if ((zero1 && zero2) || (inf1 && inf2)) begin
        nxt.cls = C_NAN;
        nxt.flg = 2'b10;
      end else if (inf1 || zero2) begin
        nxt.cls = C_INF;
        nxt.flg = {1'b0, !inf1 && !zero1};
      end else if (zero1 || inf2) begin
        nxt.cls = C_ZERO;
      end
    end else begin
      nxt.sign = s1;
      // Halve the unbiased exponent with floor, folding an odd bit into the mantissa.
      nxt.exp  = {u[12], u[12:1]} + 13'(BIAS);
      nxt.m1   = u[0] ? {1'b1, f1, 1'b0} : {2'b01, f1};
      nxt.m2   = nxt.m1;
      if (nan1) begin
        nxt.cls = C_NAN;
      end else if (s1 && !zero1) begin
        nxt.cls = C_NAN;
        nxt.flg = 2'b10;
      end else if (zero1) begin
        nxt.cls = C_ZERO;
      end else if (inf1) begin
        nxt.cls = C_INF;
      end
    end
    if (nxt.cls != C_NORM) begin
      nxt.exp = '0;
      nxt.m1  = '0;
      nxt.m2  = '0;
    end
  end

  ent_t head, skid;
  logic head_v, skid_v;
  logic push, pop;

  assign in_ready = !skid_v;
  assign push     = in_valid && in_ready;
  assign pop      = head_v && out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
      head   <= '0;
      skid   <= '0;
    end else if (flush) begin
      head_v <= 1'b0;
      skid_v <= 1'b0;
    end else if (pop) begin
      if (skid_v) begin
        head   <= skid;
        skid_v <= 1'b0;
      end else if (push) begin
        head <= nxt;
      end else begin
        head_v <= 1'b0;
      end
    end else if (push) begin
      if (!head_v) begin
        head   <= nxt;
        head_v <= 1'b1;
      end else begin
        skid   <= nxt;
        skid_v <= 1'b1;
      end
    end
  end

  assign out_valid   = head_v;
  assign out_sign    = head.sign;
  assign out_exp     = head.exp;
  assign out_mant1   = head.m1;
  assign out_mant2   = head.m2;
  assign out_class   = head.cls;
  assign out_flags   = head.flg;
  assign out_op_type = head.op;
  assign out_P       = head.p;

endmodule

// File: doc/divsqrt_unpack.md
DIVSQRT_UNPACK -- requirements
Module: divsqrt_unpack

Interface
REQ-001 SHALL have parameter BIAS, default 1023, giving the double-precision exponent bias used for all exponent arithmetic.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have port flush, input, 1, synchronous discard of all held entries.
REQ-005 SHALL have ports in_valid (input, 1) and in_ready (output, 1), the upstream handshake.
REQ-006 SHALL have ports Float1 and Float2b, input, 64 each: double-format operands already converted from single where needed.
REQ-007 SHALL have ports op_type (input, 1: 0 = divide, 1 = sqrt) and P (input, 1: 0 = double, 1 = single).
REQ-008 SHALL have ports out_valid (output, 1) and out_ready (input, 1), the downstream handshake.
REQ-009 SHALL have port out_sign, output, 1: the result sign.
REQ-010 SHALL have port out_exp, output, 13: signed, biased result exponent.
REQ-011 SHALL have ports out_mant1 and out_mant2, output, 54 each: aligned significands.
REQ-012 SHALL have port out_class, output, 2: 0 = normal, 1 = zero, 2 = inf, 3 = NaN.
REQ-013 SHALL have port out_flags, output, 2: bit1 = invalid, bit0 = divide-by-zero.
REQ-014 SHALL have ports out_op_type and out_P, output, 1 each: the captured op_type and P.

Function
REQ-015 SHALL implement a 2-entry in-order skid buffer (head entry drives outputs, plus one skid entry); a transfer occurs when valid and ready are both 1 on a clock edge.
REQ-016 SHALL drive in_ready = 1 unless both entries are occupied; in_ready SHALL depend only on registered state.
REQ-017 SHALL assert out_valid on the cycle after acceptance into an empty buffer (latency 1).
REQ-018 SHALL, on a same-cycle accept and output transfer with one entry held, keep occupancy unchanged with FIFO order preserved.
REQ-019 SHALL hold all output fields stable while out_valid = 1 and out_ready = 0.
REQ-020 SHALL classify each operand at capture: exp = 0 is zero (denormals flushed, DAZ); exp = 0x7FF with frac = 0 is inf; exp = 0x7FF with frac != 0 is NaN; all others are normal.
REQ-021 SHALL, for divide, compute sign = s1 ^ s2 and out_exp = e1 - e2 + BIAS as 13-bit signed, with no saturation.
REQ-022 SHALL, for divide, form out_mant1 = {0, 1, frac1} and out_mant2 = {0, 1, frac2}.
REQ-023 SHALL, for sqrt, compute sign = s1 and u = e1 - BIAS, then out_exp = (u >>> 1) + BIAS.
REQ-024 SHALL, for sqrt, set out_mant1 = {1, frac1, 0} when u is odd and {0, 1, frac1} when u is even; out_mant2 SHALL equal out_mant1.
REQ-025 SHALL resolve divide specials in this order:
- either operand NaN: NaN;
- 0/0 or inf/inf: NaN with invalid;
- a = inf or b = 0: inf, with divide-by-zero only when a is finite and nonzero;
- a = 0 or b = inf: zero.
REQ-026 SHALL resolve sqrt specials in this order:
- NaN: NaN;
- negative nonzero operand, including -inf: NaN with invalid;
- +/-0: zero with sign kept;
- +inf: inf.
REQ-027 SHALL, whenever out_class != 0, force out_exp and both mantissas to 0.
REQ-028 SHALL, on flush, empty both entries at the clock edge: out_valid = 0 and in_ready = 1 the next cycle; an in_valid asserted in the same cycle is dropped.
REQ-029 SHALL pass P through unchanged; P SHALL NOT alter the arithmetic, because the operands are already in double format.

Reset
REQ-030 SHALL, while reset_n = 0, asynchronously empty both entries, with out_valid = 0, in_ready = 1, and all data outputs, out_class and out_flags = 0.
REQ-031 SHALL discard any held operation when reset asserts mid-transfer; the first accept after reset_n rises SHALL behave as into an empty buffer.

Verification
REQ-032 SHALL cover divide 6.0/2.0: Float1 = 0x4018000000000000, Float2b = 0x4000000000000000, op_type = 0 -> next cycle out_exp = 1024, out_mant1 = 0x18000000000000, out_mant2 = 0x10000000000000, out_class = 0, out_sign = 0.
REQ-033 SHALL cover sqrt 2.0: Float1 = 0x4000000000000000, op_type = 1 -> out_exp = 1023, out_mant1 = 0x20000000000000 (odd exponent shift).
REQ-034 SHALL cover divide 1.0/0.0: Float1 = 0x3FF0000000000000, Float2b = 0 -> out_class = 2, out_flags = 01, out_exp = 0; and sqrt of -4.0 -> out_class = 3, out_flags = 10.
REQ-035 SHALL cover backpressure: out_ready = 0 with three back-to-back inputs -> first two accepted, in_ready = 0 after the second, third held; raising out_ready yields all three outputs in order with no loss or duplication.
REQ-036 SHALL cover a flush pulse with two entries held and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, and the concurrent input never appears at the output.
REQ-037 SHALL cover reset_n pulsed low mid-stream (asynchronously, between clock edges) -> out_valid falls immediately, and a subsequent single accept appears after exactly 1 cycle.
